// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit processor front end.
// Instruction field layout is common to fetch and decode.
package cpu_pkg;

    localparam int ADDR_W = 16;
    localparam logic [31:0] NOP = 32'hFC00_0000;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int RW_HI  = 25;
    localparam int RW_LO  = 21;
    localparam int RA_HI  = 20;
    localparam int RA_LO  = 16;
    localparam int RB_HI  = 15;
    localparam int RB_LO  = 11;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    function automatic logic [5:0] opcode_of(input logic [31:0] ins);
        return ins[OPC_HI:OPC_LO];
    endfunction

    function automatic logic [15:0] imm_of(input logic [31:0] ins);
        return ins[IMM_HI:IMM_LO];
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of {instruction, pc} between instruction memory and decode.
// Entry 0 is always the head; flush empties it without touching data.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int AW = ADDR_W
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [31:0]   push_ins_i,
    input  logic [AW-1:0] push_pc_i,
    input  logic          pop_i,
    output logic [31:0]   head_ins_o,
    output logic [AW-1:0] head_pc_o,
    output logic [1:0]    count_o
);

    logic [31:0]   ins0_q, ins0_d;
    logic [31:0]   ins1_q, ins1_d;
    logic [AW-1:0] pc0_q, pc0_d;
    logic [AW-1:0] pc1_q, pc1_d;
    logic [1:0]    count_q, count_d;

    always_comb begin
        ins0_d  = ins0_q;
        ins1_d  = ins1_q;
        pc0_d   = pc0_q;
        pc1_d   = pc1_q;
        count_d = count_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        ins0_d = push_ins_i;
                        pc0_d  = push_pc_i;
                    end else begin
                        ins1_d = push_ins_i;
                        pc1_d  = push_pc_i;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    ins0_d  = ins1_q;
                    pc0_d   = pc1_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; new entry lands behind the survivor.
                    if (count_q == 2'd2) begin
                        ins0_d = ins1_q;
                        pc0_d  = pc1_q;
                        ins1_d = push_ins_i;
                        pc1_d  = push_pc_i;
                    end else begin
                        ins0_d = push_ins_i;
                        pc0_d  = push_pc_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ins0_q  <= NOP;
            ins1_q  <= NOP;
            pc0_q   <= '0;
            pc1_q   <= '0;
            count_q <= 2'd0;
        end else begin
            ins0_q  <= ins0_d;
            ins1_q  <= ins1_d;
            pc0_q   <= pc0_d;
            pc1_q   <= pc1_d;
            count_q <= count_d;
        end
    end

    assign head_ins_o = ins0_q;
    assign head_pc_o  = pc0_q;
    assign count_o    = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-based issue to synchronous imem,
// in-flight tracking and a 2-entry buffer feeding decode.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                 ADDR_W   = cpu_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter logic [31:0]        NOP      = cpu_pkg::NOP
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [31:0]       ins,
    output logic [ADDR_W-1:0] ins_pc,
    output logic              ins_valid
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] tag_q, tag_d;
    logic              inflight_q, inflight_d;

    logic [1:0]        count;
    logic [31:0]       head_ins;
    logic [ADDR_W-1:0] head_pc;
    logic              valid;
    logic              pop;
    logic              issue;
    logic [2:0]        credit;

    assign valid = (count != 2'd0);
    assign pop   = valid & ~stall;

    // Slots already committed after this cycle's pop; pop implies count >= 1.
    assign credit = {1'b0, count} + {2'b0, inflight_q} - {2'b0, pop};
    assign issue  = ~reset & ~redirect & (credit < 3'd2);

    always_comb begin
        pc_d       = pc_q;
        tag_d      = tag_q;
        inflight_d = issue;
        if (redirect) begin
            pc_d = redirect_pc;
        end else if (issue) begin
            pc_d  = pc_q + ADDR_W'(1);
            tag_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            tag_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
        end
    end

    fetch_queue #(
        .AW(ADDR_W)
    ) u_queue (
        .clk_i      (clk),
        .reset_i    (reset),
        .flush_i    (redirect),
        .push_i     (inflight_q),
        .push_ins_i (imem_data),
        .push_pc_i  (tag_q),
        .pop_i      (pop),
        .head_ins_o (head_ins),
        .head_pc_o  (head_pc),
        .count_o    (count)
    );

    assign imem_en   = issue;
    assign imem_addr = pc_q;
    assign ins_valid = valid;
    assign ins       = valid ? head_ins : NOP;
    assign ins_pc    = valid ? head_pc : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Table-driven bench for fetch_unit with a consumption scoreboard
// and a second instance exercising PC wrap-around from RESET_PC.
module tb_fetch_unit;

    localparam logic [31:0] NOPI = 32'hFC00_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        lo = 1'b0;
    logic [15:0] lo16 = '0;

    logic        imem_en, imem_en2;
    logic [15:0] imem_addr, imem_addr2;
    logic [31:0] imem_data = '0;
    logic [31:0] imem_data2 = '0;
    logic [31:0] ins, ins2;
    logic [15:0] ins_pc, ins_pc2;
    logic        ins_valid, ins_valid2;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .reset(reset),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_data(imem_data),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .ins(ins), .ins_pc(ins_pc), .ins_valid(ins_valid)
    );

    fetch_unit #(.RESET_PC(16'hFFFE)) dut2 (
        .clk(clk), .reset(reset),
        .imem_en(imem_en2), .imem_addr(imem_addr2), .imem_data(imem_data2),
        .stall(lo), .redirect(lo), .redirect_pc(lo16),
        .ins(ins2), .ins_pc(ins_pc2), .ins_valid(ins_valid2)
    );

    function automatic logic [31:0] mem_f(input logic [15:0] a);
        return 32'h1000_0000 + {16'h0000, a};
    endfunction

    always @(posedge clk) begin
        if (imem_en)  imem_data  <= mem_f(imem_addr);
        if (imem_en2) imem_data2 <= mem_f(imem_addr2);
    end

    typedef struct {
        logic        rst;
        logic        stl;
        logic        rdr;
        logic [15:0] rpc;
        logic        v;
        logic [15:0] ipc;
        logic        en;
        logic [15:0] addr;
    } vec_t;

    typedef struct {
        logic [31:0] ins;
        logic [15:0] pc;
    } exp_t;

    vec_t tbl[29];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic rst, input logic stl,
                                input logic rdr, input logic [15:0] rpc,
                                input logic v, input logic [15:0] ipc,
                                input logic en, input logic [15:0] addr);
        vec_t r;
        r.rst = rst; r.stl = stl; r.rdr = rdr; r.rpc = rpc;
        r.v = v; r.ipc = ipc; r.en = en; r.addr = addr;
        return r;
    endfunction

    task automatic chk(input string name, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    initial begin
        //            rst stl rdr rpc       v  ipc       en addr
        tbl[0]  = mk(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
        tbl[1]  = mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000);
        tbl[2]  = mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0001);
        tbl[3]  = mk(0, 0, 0, 16'h0000, 1, 16'h0000, 1, 16'h0002);
        tbl[4]  = mk(0, 0, 0, 16'h0000, 1, 16'h0001, 1, 16'h0003);
        tbl[5]  = mk(0, 0, 0, 16'h0000, 1, 16'h0002, 1, 16'h0004);
        tbl[6]  = mk(0, 1, 0, 16'h0000, 1, 16'h0003, 0, 16'h0005);
        tbl[7]  = mk(0, 1, 0, 16'h0000, 1, 16'h0003, 0, 16'h0005);
        tbl[8]  = mk(0, 1, 0, 16'h0000, 1, 16'h0003, 0, 16'h0005);
        tbl[9]  = mk(0, 1, 0, 16'h0000, 1, 16'h0003, 0, 16'h0005);
        tbl[10] = mk(0, 0, 0, 16'h0000, 1, 16'h0003, 1, 16'h0005);
        tbl[11] = mk(0, 0, 0, 16'h0000, 1, 16'h0004, 1, 16'h0006);
        tbl[12] = mk(0, 0, 0, 16'h0000, 1, 16'h0005, 1, 16'h0007);
        tbl[13] = mk(0, 0, 0, 16'h0000, 1, 16'h0006, 1, 16'h0008);
        tbl[14] = mk(0, 0, 1, 16'h0040, 1, 16'h0007, 0, 16'h0009);
        tbl[15] = mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0040);
        tbl[16] = mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0041);
        tbl[17] = mk(0, 0, 0, 16'h0000, 1, 16'h0040, 1, 16'h0042);
        tbl[18] = mk(0, 1, 1, 16'h0080, 1, 16'h0041, 0, 16'h0043);
        tbl[19] = mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0080);
        tbl[20] = mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0081);
        tbl[21] = mk(0, 0, 0, 16'h0000, 1, 16'h0080, 1, 16'h0082);
        tbl[22] = mk(0, 0, 0, 16'h0000, 1, 16'h0081, 1, 16'h0083);
        tbl[23] = mk(0, 1, 0, 16'h0000, 1, 16'h0082, 0, 16'h0084);
        tbl[24] = mk(0, 1, 0, 16'h0000, 1, 16'h0082, 0, 16'h0084);
        tbl[25] = mk(1, 1, 0, 16'h0000, 1, 16'h0082, 0, 16'h0084);
        tbl[26] = mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000);
        tbl[27] = mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0001);
        tbl[28] = mk(0, 0, 0, 16'h0000, 1, 16'h0000, 1, 16'h0002);

        repeat (2) @(posedge clk);

        for (int i = 0; i < 29; i++) begin
            exp_t e;
            @(negedge clk);
            reset       = tbl[i].rst;
            stall       = tbl[i].stl;
            redirect    = tbl[i].rdr;
            redirect_pc = tbl[i].rpc;
            if (tbl[i].v && !tbl[i].stl) begin
                e.ins = mem_f(tbl[i].ipc);
                e.pc  = tbl[i].ipc;
                sb.push_back(e);
            end
            #1;
            chk("ins_valid", i, {31'd0, ins_valid}, {31'd0, tbl[i].v});
            chk("ins", i, ins, tbl[i].v ? mem_f(tbl[i].ipc) : NOPI);
            if (tbl[i].v || i == 0)
                chk("ins_pc", i, {16'd0, ins_pc}, {16'd0, tbl[i].ipc});
            chk("imem_en", i, {31'd0, imem_en}, {31'd0, tbl[i].en});
            chk("imem_addr", i, {16'd0, imem_addr}, {16'd0, tbl[i].addr});

            if (ins_valid && !stall) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL consume row %0d: got pc %h expected none", i, ins_pc);
                end else begin
                    e = sb.pop_front();
                    chk("sb_ins", i, ins, e.ins);
                    chk("sb_pc", i, {16'd0, ins_pc}, {16'd0, e.pc});
                end
            end

            if (i == 0)
                chk("wrap_addr_rst", i, {16'd0, imem_addr2}, 32'h0000_FFFE);
            if (i >= 3 && i <= 6) begin
                logic [15:0] p2;
                p2 = 16'hFFFE + 16'(i - 3);
                chk("wrap_valid", i, {31'd0, ins_valid2}, 32'd1);
                chk("wrap_pc", i, {16'd0, ins_pc2}, {16'd0, p2});
                chk("wrap_ins", i, ins2, mem_f(p2));
            end
        end

        chk("sb_left", 29, sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the 16-bit processor, directly upstream of the decode/control block (`DCB`). It owns the program counter, issues word addresses to the synchronous instruction memory, and buffers returned 32-bit instructions in a 2-entry queue. It presents one instruction per cycle on `ins` to decode, holds it under `stall`, and restarts cleanly on a branch/jump `redirect` from execute.

## Interface

Parameters:
- `ADDR_W`, 16: PC / instruction-memory word-address width.
- `RESET_PC`, 16'h0000: PC value loaded on reset.
- `NOP`, 32'hFC00_0000: bubble instruction (opcode 6'b111111, all fields zero).

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `reset`  in  1: reset is synchronous and active-high.
- `imem_en`  out  1: fetch request this cycle.
- `imem_addr`  out  ADDR_W: word address of the request; always equal to the PC register.
- `imem_data`  in  32: instruction data, valid exactly one cycle after an `imem_en` cycle.
- `stall`  in  1: decode cannot accept; hold the current `ins`.
- `redirect`  in  1: taken branch/jump from execute.
- `redirect_pc`  in  ADDR_W: target word address, sampled when `redirect`=1.
- `ins`  out  32: instruction to decode; equals `NOP` whenever `ins_valid`=0.
- `ins_pc`  out  ADDR_W: address of `ins`.
- `ins_valid`  out  1: `ins` is a real instruction.

## Operation

- State: `pc`; a 1-bit `inflight` flag; a 2-entry queue of {instruction, pc}; a 2-bit `count` in the range 0..2.
- Queue head drives `ins`/`ins_pc` directly from registers; `ins_valid` = (`count` != 0).
- `pop` = `ins_valid` & ~`stall`.
- `issue` = ~`reset` & ~`redirect` & ((`count` + `inflight` − `pop`) < 2). `imem_en` = `issue`.
- On `issue`: `pc` <= `pc` + 1, modulo 2^ADDR_W (16'hFFFF wraps to 16'h0000). `inflight` <= 1. The issued address is tagged for the queue.
- When `inflight`=1, `imem_data` and its tagged pc are pushed at the end of that cycle. Push and pop may occur in the same cycle. The queue never overflows; this is guaranteed by the `issue` credit rule.
- Redirect, evaluated every cycle:
  - `pc` <= `redirect_pc`; `count` <= 0; `inflight` <= 0.
  - Data returning in the redirect cycle is discarded. No issue occurs in the redirect cycle.
- Priority: `reset` > `redirect` > `stall`. With `redirect` and `stall` both high, the queue is flushed and the stall is ignored.
- Reset values: `pc`=`RESET_PC`, `count`=0, `inflight`=0, `ins`=`NOP`, `ins_pc`=0, `ins_valid`=0, `imem_en`=0, `imem_addr`=`RESET_PC`. A reset asserted mid-operation discards the queue and any in-flight data the same way.

## Timing

- Fetch latency: issue at cycle t (`imem_addr`=A); data on `imem_data` at t+1; `ins`=mem[A], `ins_valid`=1 at t+2.
- After reset deasserts at cycle 0: first issue at cycle 0, first `ins_valid` at cycle 2. Steady state thereafter is one instruction per cycle.
- Redirect at cycle r: `ins_valid`=0 from r+1 through r+2; issue of `redirect_pc` at r+1; target instruction valid at r+3. This gives 2 bubble cycles.
- Stall: `ins`/`ins_pc`/`ins_valid` remain unchanged while `stall`=1. The queue fills to 2, then `imem_en` drops. When the stall releases, the queued instructions are delivered back-to-back with no bubble, and issue resumes in the same cycle.

## Structure

- Shared package `cpu_pkg`:
  - `ADDR_W`
  - `NOP` constant
  - Instruction field positions: opcode [31:26], RW [25:21], RA [20:16], RB [15:11], imm [15:0]. These are shared with `DCB`.
- One sub-module, `fetch_queue`: 2-entry synchronous FIFO of {32-bit ins, ADDR_W pc}, with push, pop, flush and count. `fetch_unit` contains the PC, the credit/issue logic and the inflight tracking.

## Test plan

- Reset, then memory mem[i]=32'h1000_0000+i and no stall → `ins_valid` rises 2 cycles after reset release; `ins` = 32'h1000_0000, 32'h1000_0001, … one per cycle; `ins_pc` = 0, 1, 2, ….
- `stall` held 4 cycles starting while `ins`=mem[3] → `ins` stays mem[3]; `imem_en` drops after the queue holds 2; on release, mem[3] and mem[4] are delivered consecutively, then mem[5] with no gap.
- `redirect`=1 with `redirect_pc`=16'h0040 while `ins`=mem[7] → `ins_valid`=0 and `ins`=`NOP` for 2 cycles, then mem[0x40] at `ins_pc`=16'h0040; mem[8] and mem[9] are never presented.
- `redirect` and `stall` asserted together → the flush happens and `stall` is ignored; the target instruction appears 3 cycles later.
- `RESET_PC`=16'hFFFE → `ins_pc` sequence is FFFE, FFFF, 0000, 0001.
- `reset` asserted for 1 cycle mid-stream with the queue full → the next cycle shows `ins`=`NOP` and `ins_valid`=0; fetch restarts at `RESET_PC`.
